demux_stream_n: RTL and testbench

Registered, parametrised 1-to-N stream demultiplexer, the next generation of the team's 1-to-4 combinational demux. It routes each word from one valid/ready input to one of CHANNELS outputs, selected either by an address input or by an internal round-robin pointer. Every output channel has a one-entry holding register with its own valid/ready handshake, so slow consumers apply back-pressure instead of losing data. Out-of-range addresses are discarded and counted.

---
 rtl/demux_stream_n.sv | 108 ++++++++++
 tb/tb_demux_stream_n.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_n.sv
// demux_stream_n
// Registered 1-to-CHANNELS stream demultiplexer. Each input word goes to the
// channel picked by i_sel (i_mode=0) or by an internal round-robin pointer
// (i_mode=1). Every channel has a one-entry holding register with its own
// valid/ready handshake. Words addressed to a channel that does not exist are
// consumed and counted in a saturating drop counter.
//
// Ports
//   i_clk         rising-edge clock
//   i_reset       synchronous active-high reset, overrides everything
//   i_enable      1 = accept input words, 0 = input stalled (outputs drain)
//   i_mode        0 = addressed by i_sel, 1 = round-robin
//   i_sel         channel address (i_mode=0 only)
//   i_in_data     input word
//   i_in_valid    input word present
//   o_in_ready    input can be taken this cycle (combinational)
//   o_out_data    channel k at [k*WIDTH +: WIDTH]
//   o_out_valid   channel k holds a word
//   i_out_ready   consumer k takes its word this cycle
//   o_rr_ptr      current round-robin target
//   o_drop_count  out-of-range words discarded, saturates at 255
module demux_stream_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_mode,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [WIDTH-1:0]          i_in_data,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  output logic [CHANNELS*WIDTH-1:0] o_out_data,
  output logic [CHANNELS-1:0]       o_out_valid,
  input  logic [CHANNELS-1:0]       i_out_ready,
  output logic [SEL_W-1:0]          o_rr_ptr,
  output logic [7:0]                o_drop_count
);

  // One extra bit so CHANNELS == 2**SEL_W is representable for the range test.
  localparam logic [SEL_W:0]   LP_NCH  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(CHANNELS-1);

  logic [CHANNELS*WIDTH-1:0] r_data;
  logic [CHANNELS-1:0]       r_valid;
  logic [SEL_W-1:0]          r_rr_ptr;
  logic [7:0]                r_drop_count;

  logic [SEL_W-1:0]          w_target;
  logic                      w_in_range;
  logic                      w_slot_free;
  logic                      w_accept;
  logic [CHANNELS-1:0]       w_load;

  assign w_target   = i_mode ? r_rr_ptr : i_sel;
  assign w_in_range = ({1'b0, w_target} < LP_NCH);

  // Decoded lookup avoids indexing r_valid with an out-of-range target.
  always_comb begin
    w_slot_free = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_target == SEL_W'(k)) w_slot_free = ~r_valid[k] | i_out_ready[k];
    end
  end

  assign o_in_ready = i_enable & ~i_reset & (~w_in_range | w_slot_free);
  assign w_accept   = i_in_valid & o_in_ready;

  always_comb begin
    w_load = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_load[k] = w_accept & w_in_range & (w_target == SEL_W'(k));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data       <= '0;
      r_valid      <= '0;
      r_rr_ptr     <= '0;
      r_drop_count <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        // Load wins over drain so a same-cycle drain+load keeps the slot full.
        if (w_load[k]) begin
          r_data[k*WIDTH +: WIDTH] <= i_in_data;
          r_valid[k]               <= 1'b1;
        end else if (r_valid[k] & i_out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
      if (w_accept & ~w_in_range & (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
      if (w_accept & i_mode) begin
        r_rr_ptr <= (r_rr_ptr == LP_LAST) ? '0 : r_rr_ptr + 1'b1;
      end
    end
  end

  assign o_out_data   = r_data;
  assign o_out_valid  = r_valid;
  assign o_rr_ptr     = r_rr_ptr;
  assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_demux_stream_n.sv
// tb_demux_stream_n
// Directed bench for demux_stream_n: a 4-channel instance covers addressed
// routing, back-pressure, round-robin order and stall, enable gating and
// mid-stream reset; a 3-channel instance covers out-of-range drops with a
// saturating counter and round-robin wrap at CHANNELS-1.
module tb_demux_stream_n;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        rst, en, mode, vld, rdy;
  logic [1:0]  sel;
  logic [7:0]  din;
  logic [31:0] dout;
  logic [3:0]  ovld, ordy;
  logic [1:0]  rr;
  logic [7:0]  drop;

  // 3-channel instance
  logic        rst3, en3, mode3, vld3, rdy3;
  logic [1:0]  sel3;
  logic [7:0]  din3;
  logic [23:0] dout3;
  logic [2:0]  ovld3, ordy3;
  logic [1:0]  rr3;
  logic [7:0]  drop3;

  int checks = 0;
  int errors = 0;

  demux_stream_n #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) u_dut4 (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_mode(mode), .i_sel(sel),
    .i_in_data(din), .i_in_valid(vld), .o_in_ready(rdy), .o_out_data(dout),
    .o_out_valid(ovld), .i_out_ready(ordy), .o_rr_ptr(rr), .o_drop_count(drop)
  );

  demux_stream_n #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) u_dut3 (
    .i_clk(clk), .i_reset(rst3), .i_enable(en3), .i_mode(mode3), .i_sel(sel3),
    .i_in_data(din3), .i_in_valid(vld3), .o_in_ready(rdy3), .o_out_data(dout3),
    .o_out_valid(ovld3), .i_out_ready(ordy3), .o_rr_ptr(rr3), .o_drop_count(drop3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ch4(input int k);
    return dout[k*8 +: 8];
  endfunction

  initial begin : stim
    int exp_ch [6] = '{0, 1, 2, 3, 0, 1};
    int bad;

    rst = 1; en = 1; mode = 0; sel = 0; din = 8'hFF; vld = 1; ordy = 0;
    rst3 = 1; en3 = 1; mode3 = 0; sel3 = 0; din3 = 0; vld3 = 0; ordy3 = 0;
    #1;
    chk("in_ready_in_reset", {31'd0, rdy}, 32'd0);
    tick(); tick();
    chk("reset_out_valid", {28'd0, ovld}, 32'h0);
    chk("reset_out_data", dout, 32'h0);
    chk("reset_rr_ptr", {30'd0, rr}, 32'd0);
    chk("reset_drop", {24'd0, drop}, 32'd0);
    chk("in_ready_in_reset2", {31'd0, rdy}, 32'd0);
    rst = 0; rst3 = 0; vld = 0;

    // Addressed write to channel 2, then back-pressure on a second word
    sel = 2; din = 8'hA5; vld = 1;
    #1 chk("addr_in_ready", {31'd0, rdy}, 32'd1);
    tick();
    chk("addr_out_valid", {28'd0, ovld}, 32'h4);
    chk("addr_ch2_data", {24'd0, ch4(2)}, 32'hA5);
    din = 8'h5A;
    #1 chk("addr_full_in_ready", {31'd0, rdy}, 32'd0);
    tick();
    chk("addr_held_valid", {28'd0, ovld}, 32'h4);
    chk("addr_held_data", {24'd0, ch4(2)}, 32'hA5);
    ordy = 4'b0100;
    #1 chk("addr_drain_in_ready", {31'd0, rdy}, 32'd1);
    tick();
    chk("addr_reload_valid", {28'd0, ovld}, 32'h4);
    chk("addr_reload_data", {24'd0, ch4(2)}, 32'h5A);
    chk("addr_rr_unmoved", {30'd0, rr}, 32'd0);
    vld = 0;
    tick();
    chk("addr_drained", {28'd0, ovld}, 32'h0);
    chk("addr_data_kept", {24'd0, ch4(2)}, 32'h5A);

    // Round-robin, all consumers ready, 6 words back-to-back
    mode = 1; ordy = 4'hF; vld = 1;
    for (int i = 0; i < 6; i++) begin
      din = 8'(i + 1);
      #1 chk("rr_in_ready", {31'd0, rdy}, 32'd1);
      tick();
      chk("rr_data", {24'd0, ch4(exp_ch[i])}, 32'(i + 1));
      chk("rr_valid_bit", {31'd0, ovld[exp_ch[i]]}, 32'd1);
    end
    vld = 0;
    chk("rr_ptr_end", {30'd0, rr}, 32'd2);
    chk("rr_valid_end", {28'd0, ovld}, 32'h2);
    tick();
    chk("rr_all_drained", {28'd0, ovld}, 32'h0);

    // Round-robin stall on full channel 1
    ordy = 0; mode = 0; sel = 1; din = 8'h31; vld = 1;
    tick();
    mode = 1;
    din = 8'h41; tick();
    din = 8'h42; tick();
    din = 8'h43; tick();
    chk("stall_ptr_at1", {30'd0, rr}, 32'd1);
    chk("stall_all_full", {28'd0, ovld}, 32'hF);
    din = 8'h44;
    #1 chk("stall_in_ready", {31'd0, rdy}, 32'd0);
    tick();
    chk("stall_ptr_held", {30'd0, rr}, 32'd1);
    chk("stall_ch1_held", {24'd0, ch4(1)}, 32'h31);
    ordy = 4'b0010;
    #1 chk("stall_release_rdy", {31'd0, rdy}, 32'd1);
    tick();
    chk("stall_ch1_reload", {24'd0, ch4(1)}, 32'h44);
    chk("stall_ch1_valid", {28'd0, ovld}, 32'hF);
    chk("stall_ptr_moved", {30'd0, rr}, 32'd2);
    vld = 0;

    // Enable=0: input stalled while channels 0 and 3 drain
    ordy = 4'b0110;
    tick();
    chk("en_pre_valid", {28'd0, ovld}, 32'h9);
    en = 0; vld = 1; din = 8'h77; ordy = 4'b1001;
    #1 chk("en_in_ready", {31'd0, rdy}, 32'd0);
    tick();
    chk("en_drained", {28'd0, ovld}, 32'h0);
    chk("en_ch0_kept", {24'd0, ch4(0)}, 32'h43);
    chk("en_ch3_kept", {24'd0, ch4(3)}, 32'h42);
    chk("en_ptr_kept", {30'd0, rr}, 32'd2);
    en = 1; ordy = 0;

    // Mid-stream reset with pointer at 3 and two channels full
    mode = 0; sel = 0; din = 8'h50;
    tick();
    mode = 1; din = 8'h51;
    tick();
    chk("mid_pre_ptr", {30'd0, rr}, 32'd3);
    chk("mid_pre_valid", {28'd0, ovld}, 32'h5);
    rst = 1; din = 8'h52;
    #1 chk("mid_rst_in_ready", {31'd0, rdy}, 32'd0);
    tick();
    chk("mid_rst_valid", {28'd0, ovld}, 32'h0);
    chk("mid_rst_ptr", {30'd0, rr}, 32'd0);
    chk("mid_rst_drop", {24'd0, drop}, 32'd0);
    chk("mid_rst_data", dout, 32'h0);
    rst = 0; din = 8'h61;
    tick();
    chk("mid_first_valid", {28'd0, ovld}, 32'h1);
    chk("mid_first_data", {24'd0, ch4(0)}, 32'h61);
    chk("mid_first_ptr", {30'd0, rr}, 32'd1);
    vld = 0;

    // 3 channels: out-of-range address drops and saturating counter
    sel3 = 3; vld3 = 1; bad = 0;
    for (int i = 0; i < 300; i++) begin
      din3 = 8'(i);
      if (rdy3 !== 1'b1) bad++;
      tick();
      if (ovld3 !== 3'b000) bad++;
      if (i == 99) chk("drop_at_100", {24'd0, drop3}, 32'd100);
    end
    vld3 = 0;
    chk("drop_no_side_effects", 32'(bad), 32'd0);
    chk("drop_saturated", {24'd0, drop3}, 32'd255);
    chk("drop_data_untouched", {8'd0, dout3}, 32'h0);

    // 3 channels: round-robin wraps after channel 2
    mode3 = 1; ordy3 = 3'b111; vld3 = 1;
    din3 = 8'hC0; tick();
    din3 = 8'hC1; tick();
    din3 = 8'hC2; tick();
    chk("rr3_wrap_ptr", {30'd0, rr3}, 32'd0);
    chk("rr3_ch2_data", {24'd0, dout3[16 +: 8]}, 32'hC2);
    din3 = 8'hC3; tick();
    chk("rr3_ch0_data", {24'd0, dout3[0 +: 8]}, 32'hC3);
    chk("rr3_ptr_end", {30'd0, rr3}, 32'd1);
    chk("rr3_drop_kept", {24'd0, drop3}, 32'd255);
    vld3 = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
